// File: rtl/pc060ha_host_sequencer.sv
// Host-side bus initiator for the PC060HA mailbox: one page-select write, then N data accesses using the slave's page auto-increment.
// Optional `PC060HA_PAGE_SKIP_EN: skip the page write when the tracked slave page pointer already matches.
module pc060ha_host_sequencer #(
   parameter int unsigned DATA_W      = 4,
   parameter int unsigned MAX_WORDS   = 8,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic                          CLK,
   input  logic                          RESET,
   input  logic                          CMD_VALID,
   output logic                          CMD_READY,
   input  logic                          CMD_RW,
   input  logic [2:0]                    CMD_PAGE,
   input  logic [3:0]                    CMD_COUNT,
   input  logic [MAX_WORDS*DATA_W-1:0]   CMD_WDATA,
   output logic [MAX_WORDS*DATA_W-1:0]   RDATA,
   output logic                          DONE,
   output logic                          nCS,
   output logic                          nRD,
   output logic                          nWR,
   output logic                          A0,
   output logic [DATA_W-1:0]             DOUT,
   output logic                          DOE,
   input  logic [DATA_W-1:0]             DIN
);

   localparam int unsigned BUS_W = MAX_WORDS * DATA_W;
   localparam logic [3:0]  WS4   = 4'(WAIT_STATES);
   localparam logic [3:0]  MAXW4 = 4'(MAX_WORDS);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PG_T1 = 3'd1,
      PG_T2 = 3'd2,
      PG_T3 = 3'd3,
      AC_T1 = 3'd4,
      AC_T2 = 3'd5,
      AC_T3 = 3'd6,
      FIN   = 3'd7
   } state_t;

   state_t               state_q, state_d;
   logic                 rw_q, rw_d;
   logic [2:0]           page_q, page_d;
   logic [3:0]           count_q, count_d;
   logic [BUS_W-1:0]     wdata_q, wdata_d;
   logic [3:0]           idx_q, idx_d;
   logic [3:0]           wait_q, wait_d;
   logic [BUS_W-1:0]     rdata_q, rdata_d;
   logic                 ready_q, ready_d;
   logic                 done_q, done_d;
   logic                 ncs_q, ncs_d;
   logic                 nrd_q, nrd_d;
   logic                 nwr_q, nwr_d;
   logic                 a0_q, a0_d;
   logic [DATA_W-1:0]    dout_q, dout_d;
   logic                 doe_q, doe_d;
   logic [3:0]           cnt_sat;
   logic                 skip;
   logic [DATA_W-1:0]    wslot;
`ifdef PC060HA_PAGE_SKIP_EN
   logic [2:0]           mirror_q, mirror_d;
   logic                 mirror_vld_q, mirror_vld_d;
`endif

   // Next-state, datapath and registered-output computation
   always_comb begin
      state_d = state_q;
      rw_d    = rw_q;
      page_d  = page_q;
      count_d = count_q;
      wdata_d = wdata_q;
      idx_d   = idx_q;
      wait_d  = wait_q;
      rdata_d = rdata_q;
      cnt_sat = (CMD_COUNT > MAXW4) ? MAXW4 : CMD_COUNT;
      skip    = 1'b0;
`ifdef PC060HA_PAGE_SKIP_EN
      mirror_d     = mirror_q;
      mirror_vld_d = mirror_vld_q;
      skip         = (cnt_sat != 4'd0) && mirror_vld_q && (CMD_PAGE == mirror_q);
`endif

      case (state_q)
         IDLE: begin
            if (CMD_VALID && ready_q) begin
               rw_d    = CMD_RW;
               page_d  = CMD_PAGE;
               count_d = cnt_sat;
               wdata_d = CMD_WDATA;
               idx_d   = 4'd0;
               wait_d  = 4'd0;
               state_d = skip ? AC_T1 : PG_T1;
            end
         end
         PG_T1: begin
            wait_d  = 4'd0;
            state_d = PG_T2;
         end
         PG_T2: begin
            if (wait_q == WS4) state_d = PG_T3;
            else               wait_d  = wait_q + 4'd1;
         end
         PG_T3: begin
            idx_d   = 4'd0;
            state_d = (count_q != 4'd0) ? AC_T1 : FIN;
         end
         AC_T1: begin
            wait_d  = 4'd0;
            state_d = AC_T2;
         end
         AC_T2: begin
            if (wait_q == WS4) state_d = AC_T3;
            else               wait_d  = wait_q + 4'd1;
         end
         AC_T3: begin
            if (rw_q) begin
               for (int i = 0; i < int'(MAX_WORDS); i++) begin
                  if (idx_q == 4'(i)) rdata_d[i*DATA_W +: DATA_W] = DIN;
               end
            end
            idx_d   = idx_q + 4'd1;
            state_d = ((idx_q + 4'd1) < count_q) ? AC_T1 : FIN;
         end
         FIN: begin
`ifdef PC060HA_PAGE_SKIP_EN
            mirror_d     = 3'(page_q + count_q[2:0]);
            mirror_vld_d = 1'b1;
`endif
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      wslot = '0;
      for (int i = 0; i < int'(MAX_WORDS); i++) begin
         if (idx_d == 4'(i)) wslot = wdata_d[i*DATA_W +: DATA_W];
      end

      // Bus pins reflect the state being entered, so they are registered yet aligned to it
      ready_d = 1'b0;
      done_d  = 1'b0;
      ncs_d   = 1'b1;
      nrd_d   = 1'b1;
      nwr_d   = 1'b1;
      a0_d    = 1'b1;
      doe_d   = 1'b0;
      dout_d  = dout_q;
      case (state_d)
         IDLE:  ready_d = 1'b1;
         PG_T1: begin
            ncs_d  = 1'b0;
            a0_d   = 1'b0;
            doe_d  = 1'b1;
            dout_d = DATA_W'(page_d);
         end
         PG_T2, PG_T3: begin
            ncs_d = 1'b0;
            a0_d  = 1'b0;
            doe_d = 1'b1;
            nwr_d = 1'b0;
         end
         AC_T1: begin
            ncs_d = 1'b0;
            doe_d = ~rw_d;
            if (!rw_d) dout_d = wslot;
         end
         AC_T2, AC_T3: begin
            ncs_d = 1'b0;
            doe_d = ~rw_d;
            if (rw_d) nrd_d = 1'b0;
            else      nwr_d = 1'b0;
         end
         FIN:     done_d = 1'b1;
         default: ready_d = 1'b0;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= IDLE;
         rw_q    <= 1'b0;
         page_q  <= 3'd0;
         count_q <= 4'd0;
         wdata_q <= '0;
         idx_q   <= 4'd0;
         wait_q  <= 4'd0;
         rdata_q <= '0;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
         ncs_q   <= 1'b1;
         nrd_q   <= 1'b1;
         nwr_q   <= 1'b1;
         a0_q    <= 1'b1;
         dout_q  <= '0;
         doe_q   <= 1'b0;
`ifdef PC060HA_PAGE_SKIP_EN
         mirror_q     <= 3'd0;
         mirror_vld_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         rw_q    <= rw_d;
         page_q  <= page_d;
         count_q <= count_d;
         wdata_q <= wdata_d;
         idx_q   <= idx_d;
         wait_q  <= wait_d;
         rdata_q <= rdata_d;
         ready_q <= ready_d;
         done_q  <= done_d;
         ncs_q   <= ncs_d;
         nrd_q   <= nrd_d;
         nwr_q   <= nwr_d;
         a0_q    <= a0_d;
         dout_q  <= dout_d;
         doe_q   <= doe_d;
`ifdef PC060HA_PAGE_SKIP_EN
         mirror_q     <= mirror_d;
         mirror_vld_q <= mirror_vld_d;
`endif
      end
   end

   assign CMD_READY = ready_q;
   assign RDATA     = rdata_q;
   assign DONE      = done_q;
   assign nCS       = ncs_q;
   assign nRD       = nrd_q;
   assign nWR       = nwr_q;
   assign A0        = a0_q;
   assign DOUT      = dout_q;
   assign DOE       = doe_q;

endmodule

// File: tb/tb_pc060ha_host_sequencer.sv
// Directed bench for pc060ha_host_sequencer: a behavioural PC060HA slave on dut0 (no wait states) and a strobe monitor on dut2 (2 wait states).
module tb_pc060ha_host_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rw = 1'b0;
   logic [2:0]  page = 3'd0;
   logic [3:0]  count = 4'd0;
   logic [31:0] wdata = '0;

   logic        valid0 = 1'b0, ready0, done0, ncs0, nrd0, nwr0, a00, doe0;
   logic [31:0] rdata0;
   logic [3:0]  dout0, din0;
   logic        valid2 = 1'b0, ready2, done2, ncs2, nrd2, nwr2, a02, doe2;
   logic [31:0] rdata2;
   logic [3:0]  dout2;
   logic [3:0]  din2 = 4'd0;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pc060ha_host_sequencer #(.DATA_W(4), .MAX_WORDS(8), .WAIT_STATES(0)) dut0 (
      .CLK(clk), .RESET(rst), .CMD_VALID(valid0), .CMD_READY(ready0), .CMD_RW(rw),
      .CMD_PAGE(page), .CMD_COUNT(count), .CMD_WDATA(wdata), .RDATA(rdata0), .DONE(done0),
      .nCS(ncs0), .nRD(nrd0), .nWR(nwr0), .A0(a00), .DOUT(dout0), .DOE(doe0), .DIN(din0));

   pc060ha_host_sequencer #(.DATA_W(4), .MAX_WORDS(8), .WAIT_STATES(2)) dut2 (
      .CLK(clk), .RESET(rst), .CMD_VALID(valid2), .CMD_READY(ready2), .CMD_RW(rw),
      .CMD_PAGE(page), .CMD_COUNT(count), .CMD_WDATA(wdata), .RDATA(rdata2), .DONE(done2),
      .nCS(ncs2), .nRD(nrd2), .nWR(nwr2), .A0(a02), .DOUT(dout2), .DOE(doe2), .DIN(din2));

   // Slave model: latch page on nWR rise with A0=0, auto-increment on any data strobe rise
   logic [2:0]  spage = 3'd0;
   logic [3:0]  sp4;
   logic        pnwr = 1'b1, pnrd = 1'b1, pa0 = 1'b1;
   logic [3:0]  pdout = 4'd0;
   int          pgw = 0;
   int          lowrun = 0;
   logic [4:0]  wlog[$];
   int          lows[$];
   logic        pnwr2 = 1'b1;
   int          lowrun2 = 0;
   int          lows2[$];

   assign sp4  = {1'b0, spage};
   assign din0 = sp4 * 4'd3;

   always @(negedge clk) begin
      if (!pnwr && nwr0) begin
         lows.push_back(lowrun);
         lowrun = 0;
         wlog.push_back({pa0, pdout});
         if (!pa0) begin
            spage = pdout[2:0];
            pgw++;
         end else begin
            spage = spage + 3'd1;
         end
      end
      if (!pnrd && nrd0) spage = spage + 3'd1;
      if (!nwr0) lowrun++;
      pnwr  = nwr0;
      pnrd  = nrd0;
      pa0   = a00;
      pdout = dout0;
      if (!pnwr2 && nwr2) begin
         lows2.push_back(lowrun2);
         lowrun2 = 0;
      end
      if (!nwr2) lowrun2++;
      pnwr2 = nwr2;
   end

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic issue0(input logic r, input logic [2:0] p, input logic [3:0] c,
                         input logic [31:0] wd, output int done_at, output logic rdy_at_done);
      wlog.delete();
      lows.delete();
      pgw = 0;
      rw = r; page = p; count = c; wdata = wd; valid0 = 1'b1;
      @(negedge clk);
      valid0 = 1'b0;
      done_at = -1;
      rdy_at_done = 1'bx;
      for (int n = 1; n <= 100; n++) begin
         if (done0 === 1'b1) begin
            done_at = n;
            rdy_at_done = ready0;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      int dones;
      @(negedge clk);
      do_reset();
      if ({ready0, done0, ncs0, nrd0, nwr0, a00, doe0} !== 7'b1011110) begin
         bad++; $display("FAIL reset_pins got %b want 1011110", {ready0, done0, ncs0, nrd0, nwr0, a00, doe0});
      end
      total++;
      if (dout0 !== 4'd0 || rdata0 !== 32'd0) begin
         bad++; $display("FAIL reset_data got dout=%h rdata=%h want 0/0", dout0, rdata0);
      end
      total++;
      rw = 1'b0; page = 3'd1; count = 4'd8; wdata = 32'h1234_5678; valid0 = 1'b1;
      @(negedge clk);
      valid0 = 1'b0;
      repeat (5) @(negedge clk);
      if (ncs0 !== 1'b0) begin
         bad++; $display("FAIL midcmd_busy got ncs=%b want 0", ncs0);
      end
      total++;
      do_reset();
      if ({ready0, done0, ncs0, nrd0, nwr0, a00, doe0} !== 7'b1011110) begin
         bad++; $display("FAIL abort_pins got %b want 1011110", {ready0, done0, ncs0, nrd0, nwr0, a00, doe0});
      end
      total++;
      dones = 0;
      repeat (30) begin
         @(negedge clk);
         if (done0 === 1'b1) dones++;
      end
      if (dones !== 0) begin
         bad++; $display("FAIL abort_no_done got %0d pulses want 0", dones);
      end
      total++;
   endtask

   task automatic test_write();
      int d;
      logic rd;
      logic [4:0] exp[4];
      exp = '{5'h02, 5'h1A, 5'h15, 5'h1C};
      issue0(1'b0, 3'd2, 4'd3, 32'h0000_0C5A, d, rd);
      if (d !== 13) begin bad++; $display("FAIL write_done got %0d want 13", d); end
      total++;
      if (rd !== 1'b0) begin bad++; $display("FAIL write_ready_at_fin got %b want 0", rd); end
      total++;
      if (wlog.size() !== 4) begin bad++; $display("FAIL write_count got %0d want 4", wlog.size()); end
      total++;
      for (int i = 0; i < 4; i++) begin
         if (i < wlog.size()) begin
            if (wlog[i] !== exp[i]) begin bad++; $display("FAIL write_bus%0d got %h want %h", i, wlog[i], exp[i]); end
            total++;
            if (lows[i] !== 2) begin bad++; $display("FAIL write_low%0d got %0d want 2", i, lows[i]); end
            total++;
         end
      end
   endtask

   task automatic test_read();
      int d;
      logic rd;
      issue0(1'b1, 3'd6, 4'd4, 32'h0, d, rd);
      if (d !== 16) begin bad++; $display("FAIL read_done got %0d want 16", d); end
      total++;
      if (rdata0 !== 32'h0000_3052) begin bad++; $display("FAIL read_data got %h want 00003052", rdata0); end
      total++;
      if (pgw !== 1) begin bad++; $display("FAIL read_pagewr got %0d want 1", pgw); end
      total++;
   endtask

   task automatic test_count0();
      int d;
      logic rd;
      issue0(1'b0, 3'd5, 4'd0, 32'hFFFF_FFFF, d, rd);
      if (d !== 4) begin bad++; $display("FAIL count0_done got %0d want 4", d); end
      total++;
      if (wlog.size() !== 1) begin
         bad++; $display("FAIL count0_writes got %0d want 1", wlog.size());
      end else if (wlog[0] !== 5'h05) begin
         bad++; $display("FAIL count0_bus got %h want 05", wlog[0]);
      end
      total++;
   endtask

   task automatic test_saturate();
      int d;
      logic rd;
      issue0(1'b0, 3'd0, 4'd12, 32'h8765_4321, d, rd);
      if (d !== 28) begin bad++; $display("FAIL sat_done got %0d want 28", d); end
      total++;
      if (wlog.size() !== 9) begin
         bad++; $display("FAIL sat_writes got %0d want 9", wlog.size());
      end else if (wlog[1] !== 5'h11 || wlog[8] !== 5'h18) begin
         bad++; $display("FAIL sat_bus got %h/%h want 11/18", wlog[1], wlog[8]);
      end
      total++;
      if (rdata0 !== 32'h0000_3052) begin bad++; $display("FAIL sat_rdata_hold got %h want 00003052", rdata0); end
      total++;
   endtask

   task automatic test_wait();
      int d;
      lows2.delete();
      rw = 1'b0; page = 3'd1; count = 4'd1; wdata = 32'h9; valid2 = 1'b1;
      @(negedge clk);
      valid2 = 1'b0;
      d = -1;
      for (int n = 1; n <= 100; n++) begin
         if (done2 === 1'b1) begin d = n; break; end
         @(negedge clk);
      end
      @(negedge clk);
      if (d !== 11) begin bad++; $display("FAIL wait_done got %0d want 11", d); end
      total++;
      if (lows2.size() !== 2) begin
         bad++; $display("FAIL wait_strobes got %0d want 2", lows2.size());
      end else if (lows2[0] !== 4 || lows2[1] !== 4) begin
         bad++; $display("FAIL wait_low got %0d/%0d want 4/4", lows2[0], lows2[1]);
      end
      total++;
   endtask

   task automatic test_back_to_back();
      int d;
      logic rd;
      int exp_pg;
      int exp_d;
`ifdef PC060HA_PAGE_SKIP_EN
      exp_pg = 0; exp_d = 4;
`else
      exp_pg = 1; exp_d = 7;
`endif
      issue0(1'b0, 3'd3, 4'd2, 32'h0000_00BE, d, rd);
      if (d !== 10) begin bad++; $display("FAIL b2b_first_done got %0d want 10", d); end
      total++;
      issue0(1'b1, 3'd5, 4'd1, 32'h0, d, rd);
      if (pgw !== exp_pg) begin bad++; $display("FAIL b2b_pagewr got %0d want %0d", pgw, exp_pg); end
      total++;
      if (d !== exp_d) begin bad++; $display("FAIL b2b_done got %0d want %0d", d, exp_d); end
      total++;
      if (rdata0 !== 32'h0000_305F) begin bad++; $display("FAIL b2b_rdata got %h want 0000305F", rdata0); end
      total++;
      do_reset();
      issue0(1'b1, 3'd5, 4'd1, 32'h0, d, rd);
      if (pgw !== 1) begin bad++; $display("FAIL postrst_pagewr got %0d want 1", pgw); end
      total++;
      if (d !== 7) begin bad++; $display("FAIL postrst_done got %0d want 7", d); end
      total++;
      if (rdata0 !== 32'h0000_000F) begin bad++; $display("FAIL postrst_rdata got %h want 0000000F", rdata0); end
      total++;
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_count0();
      test_saturate();
      test_wait();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
